// File: rtl/i2cs_pkg.sv
// Shared constants for the I2C peripheral pin conditioner.
package i2cs_pkg;

    localparam int unsigned LEN_W_DEFAULT = 8;
    localparam int unsigned GLITCH_CNT_W  = 16;
    localparam int unsigned DEBOUNCE_MIN  = 1;
    localparam logic        I2C_LINE_IDLE = 1'b1;

endpackage

// File: rtl/i2cs_line_filter.sv
// Synchroniser plus debounce filter for one I2C line.
// I2CS_GLITCH_STATS_EN adds a glitch-event output.
module i2cs_line_filter
    import i2cs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = LEN_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LEN_W-1:0] debounce_len_i,
    input  logic             line_i,
    output logic             filt_o
`ifdef I2CS_GLITCH_STATS_EN
    ,
    output logic             glitch_o
`endif
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [LEN_W-1:0]       cnt_q;
    logic                   filt_q;
    logic                   synced;
    logic [LEN_W-1:0]       thresh;
    logic [LEN_W:0]         cnt_inc;

    assign synced  = sync_q[SYNC_STAGES-1];
    assign thresh  = (debounce_len_i == '0) ? LEN_W'(DEBOUNCE_MIN) : debounce_len_i;
    assign cnt_inc = {1'b0, cnt_q} + (LEN_W+1)'(1);

    // NOTE: >= rather than == so a threshold lowered below the running count
    // still accepts the change on the next compare instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{I2C_LINE_IDLE}};
            cnt_q  <= '0;
            filt_q <= I2C_LINE_IDLE;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
            if (synced != filt_q) begin
                if (cnt_inc >= {1'b0, thresh}) begin
                    filt_q <= synced;
                    cnt_q  <= '0;
                end else begin
                    cnt_q <= cnt_inc[LEN_W-1:0];
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign filt_o = filt_q;

`ifdef I2CS_GLITCH_STATS_EN
    // A partial count abandoned because the line fell back is a rejected glitch.
    assign glitch_o = (synced == filt_q) && (cnt_q != '0);
`endif

endmodule

// File: rtl/i2cs_pin_conditioner.sv
// I2C pin front end: filtered levels, SCL edge and START/STOP pulses, delayed SDA drive.
// Optional rejected-glitch statistics under I2CS_GLITCH_STATS_EN.
module i2cs_pin_conditioner
    import i2cs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LEN_W       = LEN_W_DEFAULT
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [LEN_W-1:0]        debounce_len_i,
    input  logic [LEN_W-1:0]        sda_delay_len_i,
    input  logic                    i2c_scl_i,
    input  logic                    i2c_sda_i,
    input  logic                    sda_out_req_i,
    output logic                    scl_o,
    output logic                    sda_o,
    output logic                    scl_rise_o,
    output logic                    scl_fall_o,
    output logic                    start_o,
    output logic                    stop_o,
    output logic                    busy_o,
    output logic                    sda_out_o,
    output logic [GLITCH_CNT_W-1:0] glitch_cnt_o
);

    logic scl_f, sda_f;
    logic scl_prev_q, sda_prev_q;
    logic rise_det, fall_det, start_det, stop_det;
    logic [LEN_W-1:0] dly_cnt_q;
    logic             dly_pend_q;

`ifdef I2CS_GLITCH_STATS_EN
    logic scl_glitch, sda_glitch;
`endif

    i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES), .LEN_W(LEN_W)) u_scl_filter (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .debounce_len_i (debounce_len_i),
        .line_i         (i2c_scl_i),
        .filt_o         (scl_f)
`ifdef I2CS_GLITCH_STATS_EN
        ,
        .glitch_o       (scl_glitch)
`endif
    );

    i2cs_line_filter #(.SYNC_STAGES(SYNC_STAGES), .LEN_W(LEN_W)) u_sda_filter (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .debounce_len_i (debounce_len_i),
        .line_i         (i2c_sda_i),
        .filt_o         (sda_f)
`ifdef I2CS_GLITCH_STATS_EN
        ,
        .glitch_o       (sda_glitch)
`endif
    );

    // START/STOP need SCL high both before and after the SDA toggle, which
    // also rejects simultaneous SCL/SDA changes.
    assign rise_det  = enable_i & ~scl_prev_q & scl_f;
    assign fall_det  = enable_i & scl_prev_q & ~scl_f;
    assign start_det = enable_i & scl_prev_q & scl_f & sda_prev_q & ~sda_f;
    assign stop_det  = enable_i & scl_prev_q & scl_f & ~sda_prev_q & sda_f;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_prev_q <= I2C_LINE_IDLE;
            sda_prev_q <= I2C_LINE_IDLE;
            scl_rise_o <= 1'b0;
            scl_fall_o <= 1'b0;
            start_o    <= 1'b0;
            stop_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            scl_prev_q <= scl_f;
            sda_prev_q <= sda_f;
            scl_rise_o <= rise_det;
            scl_fall_o <= fall_det;
            start_o    <= start_det;
            stop_o     <= stop_det;
            if (!enable_i || stop_det) begin
                busy_o <= 1'b0;
            end else if (start_det) begin
                busy_o <= 1'b1;
            end
        end
    end

    // The load shares the edge that raises scl_fall_o, so a zero delay
    // updates sda_out_o one cycle after the pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dly_cnt_q  <= '0;
            dly_pend_q <= 1'b0;
            sda_out_o  <= I2C_LINE_IDLE;
        end else if (!enable_i || stop_det) begin
            dly_cnt_q  <= '0;
            dly_pend_q <= 1'b0;
            sda_out_o  <= I2C_LINE_IDLE;
        end else if (fall_det) begin
            dly_cnt_q  <= sda_delay_len_i;
            dly_pend_q <= 1'b1;
        end else if (dly_cnt_q != '0) begin
            dly_cnt_q <= dly_cnt_q - LEN_W'(1);
        end else if (dly_pend_q) begin
            sda_out_o  <= sda_out_req_i;
            dly_pend_q <= 1'b0;
        end
    end

    assign scl_o = scl_f;
    assign sda_o = sda_f;

`ifdef I2CS_GLITCH_STATS_EN
    logic [GLITCH_CNT_W-1:0] glitch_cnt_q;
    logic [GLITCH_CNT_W:0]   glitch_sum;

    assign glitch_sum = {1'b0, glitch_cnt_q} + (GLITCH_CNT_W+1)'(scl_glitch)
                      + (GLITCH_CNT_W+1)'(sda_glitch);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            glitch_cnt_q <= '0;
        end else begin
            glitch_cnt_q <= glitch_sum[GLITCH_CNT_W] ? '1 : glitch_sum[GLITCH_CNT_W-1:0];
        end
    end

    assign glitch_cnt_o = glitch_cnt_q;
`else
    assign glitch_cnt_o = '0;
`endif

endmodule
